// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front-end for a combinational WIDTH-bit ALU. Commands arrive over a
// valid/ready interface into a DEPTH-entry FIFO. An IDLE/EXEC/RESP FSM pops one
// command at a time. It presents accumulator / operand / op_sel to the external
// ALU for one EXEC cycle, writes the result back to the accumulator, and
// returns the result plus flags on a valid/ready response interface.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready = FIFO not full)
//   cmd_op/cmd_load/cmd_data command payload (load bypasses the ALU)
//   alu_a/alu_b/alu_op_sel   registered drive to the external ALU
//   alu_result/zero/carry/overflow  ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready      response handshake
//   rsp_result/zero/carry/overflow  captured response payload
//   acc_out                  current accumulator
//   sticky_ovf/clr_sticky    sticky overflow flag and its clear
//   busy                     FSM not idle or commands queued
//   fifo_count               FIFO occupancy
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,   // power of two, >= 2
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic                     cmd_load,
    input  logic [WIDTH-1:0]         cmd_data,

    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_op_sel,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_carry,
    input  logic                     alu_overflow,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_carry,
    output logic                     rsp_overflow,

    output logic [WIDTH-1:0]         acc_out,
    output logic                     sticky_ovf,
    input  logic                     clr_sticky,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [2:0]        r_fifo_op   [DEPTH];
    logic [WIDTH-1:0]  r_fifo_data [DEPTH];
    logic [DEPTH-1:0]  r_fifo_load;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    state_t            r_state;
    logic [2:0]        r_cur_op;
    logic [WIDTH-1:0]  r_cur_data;
    logic              r_cur_load;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_acc;

    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_carry;
    logic              r_rsp_overflow;
    logic              r_sticky;

    logic              w_push;
    logic              w_pop;
    logic              w_full;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    // Full depends only on the registered count, never on a same-cycle pop.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = cmd_valid && !w_full;
    assign w_pop  = (r_state == ST_IDLE) && (r_count != CW'(0));

    // -----------------------------------------------------------------------
    // FIFO payload storage (no reset needed: only entries below count are read)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= cmd_op;
            r_fifo_data[r_wr_ptr] <= cmd_data;
            r_fifo_load[r_wr_ptr] <= cmd_load;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sequencing FSM with registered ALU drive, accumulator and response
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cur_op       <= 3'd0;
            r_cur_data     <= WIDTH'(0);
            r_cur_load     <= 1'b0;
            r_alu_a        <= WIDTH'(0);
            r_acc          <= WIDTH'(0);
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= WIDTH'(0);
            r_rsp_zero     <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_sticky       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur_op   <= r_fifo_op[r_rd_ptr];
                        r_cur_data <= r_fifo_data[r_rd_ptr];
                        r_cur_load <= r_fifo_load[r_rd_ptr];
                        // acc cannot change between pop and end of EXEC
                        r_alu_a    <= r_acc;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cur_load) begin
                        r_acc          <= r_cur_data;
                        r_rsp_result   <= r_cur_data;
                        r_rsp_zero     <= (r_cur_data == WIDTH'(0));
                        r_rsp_carry    <= 1'b0;
                        r_rsp_overflow <= 1'b0;
                    end else begin
                        r_acc          <= alu_result;
                        r_rsp_result   <= alu_result;
                        r_rsp_zero     <= alu_zero;
                        r_rsp_carry    <= alu_carry;
                        r_rsp_overflow <= alu_overflow;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase

            // A set on this edge takes priority over a clear
            if ((r_state == ST_EXEC) && !r_cur_load && alu_overflow) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping (all from registers)
    // -----------------------------------------------------------------------
    assign cmd_ready    = !w_full;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_cur_data;
    assign alu_op_sel   = r_cur_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign acc_out      = r_acc;
    assign sticky_ovf   = r_sticky;
    assign busy         = (r_state != ST_IDLE) || (r_count != CW'(0));
    assign fifo_count   = r_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU
// (000 = ADD, 001 = SUB; carry = carry-out / borrow).
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_load;
    logic [7:0] cmd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op_sel;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_overflow;
    logic [7:0] acc_out;
    logic       sticky_ovf;
    logic       clr_sticky;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rsp_cyc = 0;
    int last_gap = 0;

    logic [8:0] alu_t;

    alu_cmd_sequencer #(.DEPTH(4), .WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_load     (cmd_load),
        .cmd_data     (cmd_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op_sel   (alu_op_sel),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .acc_out      (acc_out),
        .sticky_ovf   (sticky_ovf),
        .clr_sticky   (clr_sticky),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU
    always_comb begin
        alu_t = 9'd0;
        if (alu_op_sel == 3'b001) begin
            alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        end else begin
            alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        end
        alu_result = alu_t[7:0];
        alu_zero   = (alu_t[7:0] == 8'd0);
        alu_carry  = alu_t[8];
        if (alu_op_sel == 3'b001) begin
            alu_overflow = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
        end else begin
            alu_overflow = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until accepted (bounded)
    task automatic push(input logic [2:0] op, input logic ld, input logic [7:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_load  = ld;
        cmd_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("push_accept", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, and let it be consumed
    task automatic get_rsp(input string tag, input logic [7:0] er, input logic ez,
                           input logic ec, input logic ev);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        last_gap     = cyc - last_rsp_cyc;
        last_rsp_cyc = cyc;
        check({tag, "_result"}, 32'(rsp_result), 32'(er));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
        check({tag, "_carry"}, 32'(rsp_carry), 32'(ec));
        check({tag, "_ovf"}, 32'(rsp_overflow), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_load   = 1'b0;
        cmd_data   = 8'd0;
        rsp_ready  = 1'b1;
        clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_acc", 32'(acc_out), 32'h00);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Load 0x7F then ADD 0x01 -> signed overflow
        push(3'b000, 1'b1, 8'h7F);
        push(3'b000, 1'b0, 8'h01);
        get_rsp("ld7f", 8'h7F, 1'b0, 1'b0, 1'b0);
        get_rsp("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1);
        check("acc_80", 32'(acc_out), 32'h80);
        check("sticky_set", 32'(sticky_ovf), 32'd1);

        // Load 0xFF then ADD 0x01 -> carry wrap, sticky untouched
        push(3'b000, 1'b1, 8'hFF);
        push(3'b000, 1'b0, 8'h01);
        get_rsp("ldff", 8'hFF, 1'b0, 1'b0, 1'b0);
        get_rsp("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0);
        check("acc_00", 32'(acc_out), 32'h00);
        check("sticky_hold", 32'(sticky_ovf), 32'd1);

        // clr_sticky alone
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("sticky_clr", 32'(sticky_ovf), 32'd0);

        // Latency: SUB 0x00 - 0x05 pushed at edge N
        push(3'b001, 1'b0, 8'h05);
        check("lat_n0_valid", 32'(rsp_valid), 32'd0);
        check("lat_n0_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("lat_n1_valid", 32'(rsp_valid), 32'd0);
        check("lat_exec_a", 32'(alu_a), 32'h00);
        check("lat_exec_b", 32'(alu_b), 32'h05);
        check("lat_exec_op", 32'(alu_op_sel), 32'd1);
        @(posedge clk);
        #1;
        check("lat_n2_valid", 32'(rsp_valid), 32'd1);
        get_rsp("sub", 8'hFB, 1'b0, 1'b1, 1'b0);

        // Back-to-back: one response every 3 cycles
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h01);
        get_rsp("b2b0", 8'hFC, 1'b0, 1'b0, 1'b0);
        get_rsp("b2b1", 8'hFD, 1'b0, 1'b0, 1'b0);
        check("b2b_gap1", 32'(last_gap), 32'd3);
        get_rsp("b2b2", 8'hFE, 1'b0, 1'b0, 1'b0);
        check("b2b_gap2", 32'(last_gap), 32'd3);

        // Backpressure: 5 accepted, 6th refused
        rsp_ready = 1'b0;
        push(3'b000, 1'b1, 8'h10);
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h02);
        push(3'b000, 1'b0, 8'h03);
        push(3'b000, 1'b0, 8'h04);
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", 32'(fifo_count), 32'd4);
        check("bp_ready", 32'(cmd_ready), 32'd0);
        check("bp_valid", 32'(rsp_valid), 32'd1);
        check("bp_result", 32'(rsp_result), 32'h10);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_load  = 1'b0;
        cmd_data  = 8'h99;
        repeat (4) @(posedge clk);
        #1;
        check("bp_count_hold", 32'(fifo_count), 32'd4);
        check("bp_result_hold", 32'(rsp_result), 32'h10);
        check("bp_valid_hold", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        get_rsp("drain0", 8'h10, 1'b0, 1'b0, 1'b0);
        get_rsp("drain1", 8'h11, 1'b0, 1'b0, 1'b0);
        get_rsp("drain2", 8'h13, 1'b0, 1'b0, 1'b0);
        get_rsp("drain3", 8'h16, 1'b0, 1'b0, 1'b0);
        get_rsp("drain4", 8'h1A, 1'b0, 1'b0, 1'b0);
        check("drain_acc", 32'(acc_out), 32'h1A);
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Reset mid-operation with sticky set and 3 commands queued
        push(3'b000, 1'b1, 8'h7F);
        push(3'b000, 1'b0, 8'h01);
        get_rsp("r_ld", 8'h7F, 1'b0, 1'b0, 1'b0);
        get_rsp("r_add", 8'h80, 1'b0, 1'b0, 1'b1);
        check("r_sticky_pre", 32'(sticky_ovf), 32'd1);
        rsp_ready = 1'b0;
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h01);
        push(3'b000, 1'b0, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        check("r_pre_count", 32'(fifo_count), 32'd3);
        check("r_pre_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("r_valid", 32'(rsp_valid), 32'd0);
        check("r_count", 32'(fifo_count), 32'd0);
        check("r_acc", 32'(acc_out), 32'h00);
        check("r_sticky", 32'(sticky_ovf), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("r_no_rsp", 32'(rsp_valid), 32'd0);

        // Sticky priority: clear held across the overflowing capture
        push(3'b000, 1'b1, 8'h7F);
        push(3'b000, 1'b0, 8'h01);
        get_rsp("p_ld", 8'h7F, 1'b0, 1'b0, 1'b0);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("p_set_wins", 32'(sticky_ovf), 32'd1);
        get_rsp("p_add", 8'h80, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("p_clr_alone", 32'(sticky_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the combinational 8-bit ALU (inputs a, b, op_sel; outputs result, zero, carry, overflow).
- Accepts operations over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU with a = accumulator and b = command operand, then writes the ALU result back into the accumulator.
- Returns each result and its flags on a valid/ready response interface, and keeps a sticky overflow flag.

Parameters:
- DEPTH, 4, command FIFO depth; power of two, at least 2.
- WIDTH, 8, datapath width; must match the ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_op  in  3  ALU op_sel for this command
- cmd_load  in  1  1 = load accumulator with cmd_data and bypass the ALU
- cmd_data  in  WIDTH  operand (ALU b) or load value
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_op_sel  out  3  to ALU op_sel
- alu_result  in  WIDTH  from ALU
- alu_zero, alu_carry, alu_overflow  in  1 each  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured result
- rsp_zero, rsp_carry, rsp_overflow  out  1 each  captured flags
- acc_out  out  WIDTH  current accumulator
- sticky_ovf  out  1  set by any ALU overflow; cleared by clr_sticky
- clr_sticky  in  1  clears sticky_ovf
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock, synchronous, active-high; the reset is sampled on the clk edge.
  - Cleared: FIFO pointers and count, acc, the cur_* registers (op/data/load), rsp_* registers, sticky_ovf.
  - FSM goes to IDLE; rsp_valid = 0; cmd_ready = 1 from the first cycle after reset.
  - A reset mid-operation drops all queued commands and any pending response.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH) and does not depend on a same-cycle pop.
  - Pop only in IDLE when count != 0.
  - Push and pop in the same cycle: count is unchanged and pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if count != 0, pop the head into cur_op/cur_data/cur_load, then go to EXEC. Otherwise stay.
  - EXEC: one cycle in which alu_a = acc, alu_b = cur_data, alu_op_sel = cur_op are stable. Those three outputs come directly from registers (no combinational path from cmd_*).
    - At the end of EXEC, non-load: acc <= alu_result; rsp_result/zero/carry/overflow <= ALU outputs.
    - At the end of EXEC, load: acc <= cur_data; rsp_result <= cur_data; rsp_zero = (cur_data == 0); rsp_carry = 0; rsp_overflow = 0.
    - Then go to RESP.
  - RESP: rsp_valid = 1 and rsp_* held stable until rsp_ready is sampled high; then go to IDLE with rsp_valid = 0 the next cycle.
- Latency and throughput:
  - A command pushed at edge N into an empty, idle block is popped at N+1.
  - Its result is captured at N+2; rsp_valid is high in the cycle after N+2.
  - With rsp_ready held high, throughput is 1 command per 3 cycles.
- sticky_ovf:
  - Set at end of EXEC when alu_overflow = 1 on a non-load command.
  - clr_sticky clears it. If set and clear happen in the same cycle, set wins.
- Arithmetic: all values are WIDTH-bit. The block performs no arithmetic of its own; flag semantics belong to the ALU.
- Outputs outside EXEC: alu_* hold their last registered values.
- Backpressure: rsp_ready low stalls the FSM in RESP. The FIFO keeps accepting until full, so the maximum number of commands outstanding is DEPTH + 1.

Test Plan:
- Bench ALU model encoding for all scenarios: 000 = ADD, 001 = SUB.
- Load and add with overflow: after reset, load 0x7F, then op 000 with data 0x01 -> responses 0x7F (zero=0) then 0x80 (overflow=1, carry=0); acc_out = 0x80; sticky_ovf = 1.
- Add with carry wrap: load 0xFF, then op 000 with data 0x01 -> result 0x00, zero=1, carry=1, overflow=0; sticky_ovf unchanged.
- Latency: single command pushed at edge N with rsp_ready = 1 -> rsp_valid first high after edge N+2. Back-to-back commands -> one response every 3 cycles.
- Backpressure and full: rsp_ready = 0, offer 6 commands -> 5 accepted (1 in FSM, 4 in FIFO), cmd_ready = 0 with fifo_count = 4. rsp_result stays stable while held. Releasing rsp_ready drains all 5 in order.
- Reset mid-operation: assert rst during RESP with 3 commands queued -> next cycle rsp_valid = 0, fifo_count = 0, acc_out = 0, sticky_ovf = 0, busy = 0, cmd_ready = 1.
- Sticky priority: clr_sticky asserted in the same cycle an overflowing ADD (0x7F + 0x01) is captured -> sticky_ovf = 1. A later clr_sticky alone -> 0.
